// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: default tag width,
// source encodings and the {result, rdTag} payload carried through the buffers.
package cdb_pkg;

  localparam int CDB_TAG_W = 4;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;

  typedef struct packed {
    logic [31:0]          result;
    logic [CDB_TAG_W-1:0] rd_tag;
  } cdb_payload_t;

endpackage

// File: rtl/cdb_fifo.sv
// Per-source completion buffer. DEPTH must be a power of two so the pointers
// wrap for free. push/pop are already qualified by the caller (ready, grant,
// global enable); flush empties the buffer synchronously and wins over both.
module cdb_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  cdb_payload_t     din,
  output cdb_payload_t     dout,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  cdb_payload_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy update; simultaneous push and pop leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are only meaningful where count says so, so no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers ALU and LSB completions and broadcasts at
// most one per cycle on the shared CDB, registered.
// Build option: CDB_ARB_RR_EN selects round-robin arbitration; when undefined
// the ALU always wins over the LSB.
// TAG_W is expected to equal CDB_TAG_W, which sizes the shared payload type.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int TAG_W  = CDB_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rollback,
  input  logic             alu_valid,
  input  logic [31:0]      alu_result,
  input  logic [TAG_W-1:0] alu_rdTag,
  output logic             alu_ready,
  input  logic             lsb_valid,
  input  logic [31:0]      lsb_result,
  input  logic [TAG_W-1:0] lsb_rdTag,
  output logic             lsb_ready,
  output logic             cdb_valid,
  output logic [31:0]      cdb_result,
  output logic [TAG_W-1:0] cdb_rdTag,
  output logic             cdb_src
);

  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);

  cdb_payload_t     alu_din, lsb_din, alu_head, lsb_head, win_head;
  logic [CNT_W-1:0] alu_cnt, lsb_cnt;
  logic             alu_push, lsb_push, alu_pop, lsb_pop;
  logic             alu_ne, lsb_ne;
  logic             grant_any, grant_src;

  logic             cdb_valid_q, cdb_valid_d;
  logic [31:0]      cdb_result_q, cdb_result_d;
  logic [TAG_W-1:0] cdb_rd_tag_q, cdb_rd_tag_d;
  logic             cdb_src_q, cdb_src_d;

  // Ready looks only at the pre-edge count, never at a same-cycle pop.
  assign alu_ready = rdy & (alu_cnt != CNT_FULL);
  assign lsb_ready = rdy & (lsb_cnt != CNT_FULL);

  // A rollback edge discards whatever is being handed over in the same cycle.
  assign alu_push = alu_valid & alu_ready & ~rollback;
  assign lsb_push = lsb_valid & lsb_ready & ~rollback;

  assign alu_din = '{result: alu_result, rd_tag: alu_rdTag};
  assign lsb_din = '{result: lsb_result, rd_tag: lsb_rdTag};

  assign alu_ne = (alu_cnt != '0);
  assign lsb_ne = (lsb_cnt != '0);

`ifdef CDB_ARB_RR_EN
  logic prio_q, prio_d;

  // Pick a winner; with both waiting, the priority pointer decides.
  always_comb begin
    grant_any = 1'b0;
    grant_src = SRC_ALU;
    if (rdy && !rollback) begin
      if (alu_ne && lsb_ne) begin
        grant_any = 1'b1;
        grant_src = prio_q;
      end else if (alu_ne) begin
        grant_any = 1'b1;
        grant_src = SRC_ALU;
      end else if (lsb_ne) begin
        grant_any = 1'b1;
        grant_src = SRC_LSB;
      end
    end
  end

  // The source not granted this cycle gets priority next time.
  always_comb begin
    prio_d = prio_q;
    if (rollback)       prio_d = SRC_ALU;
    else if (grant_any) prio_d = ~grant_src;
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prio_q <= SRC_ALU;
    else      prio_q <= prio_d;
  end
`else
  // Pick a winner; the ALU always goes first, the LSB may starve.
  always_comb begin
    grant_any = 1'b0;
    grant_src = SRC_ALU;
    if (rdy && !rollback) begin
      if (alu_ne) begin
        grant_any = 1'b1;
        grant_src = SRC_ALU;
      end else if (lsb_ne) begin
        grant_any = 1'b1;
        grant_src = SRC_LSB;
      end
    end
  end
`endif

  assign alu_pop  = grant_any & (grant_src == SRC_ALU);
  assign lsb_pop  = grant_any & (grant_src == SRC_LSB);
  assign win_head = (grant_src == SRC_LSB) ? lsb_head : alu_head;

  // Next bus contents: load the winner, drop valid when idle, hold when frozen.
  always_comb begin
    cdb_valid_d  = cdb_valid_q;
    cdb_result_d = cdb_result_q;
    cdb_rd_tag_d = cdb_rd_tag_q;
    cdb_src_d    = cdb_src_q;
    if (rollback) begin
      cdb_valid_d = 1'b0;
    end else if (rdy) begin
      cdb_valid_d = grant_any;
      if (grant_any) begin
        cdb_result_d = win_head.result;
        cdb_rd_tag_d = win_head.rd_tag;
        cdb_src_d    = grant_src;
      end
    end
  end

  // Bus output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid_q  <= 1'b0;
      cdb_result_q <= '0;
      cdb_rd_tag_q <= '0;
      cdb_src_q    <= SRC_ALU;
    end else begin
      cdb_valid_q  <= cdb_valid_d;
      cdb_result_q <= cdb_result_d;
      cdb_rd_tag_q <= cdb_rd_tag_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_result = cdb_result_q;
  assign cdb_rdTag  = cdb_rd_tag_q;
  assign cdb_src    = cdb_src_q;

  cdb_fifo #(.DEPTH(QDEPTH)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (rollback),
    .push  (alu_push),
    .pop   (alu_pop),
    .din   (alu_din),
    .dout  (alu_head),
    .count (alu_cnt)
  );

  cdb_fifo #(.DEPTH(QDEPTH)) u_lsb_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (rollback),
    .push  (lsb_push),
    .pop   (lsb_pop),
    .din   (lsb_din),
    .dout  (lsb_head),
    .count (lsb_cnt)
  );

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios followed by random traffic, all
// checked against a queue-based reference model. Honours CDB_ARB_RR_EN.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int QDEPTH = 2;
  localparam int TAG_W  = CDB_TAG_W;

  logic             clk = 1'b0;
  logic             rst, rdy, rollback;
  logic             alu_valid, lsb_valid;
  logic [31:0]      alu_result, lsb_result;
  logic [TAG_W-1:0] alu_rdTag, lsb_rdTag;
  logic             alu_ready, lsb_ready;
  logic             cdb_valid;
  logic [31:0]      cdb_result;
  logic [TAG_W-1:0] cdb_rdTag;
  logic             cdb_src;

  cdb_arbiter #(.QDEPTH(QDEPTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .rollback   (rollback),
    .alu_valid  (alu_valid),
    .alu_result (alu_result),
    .alu_rdTag  (alu_rdTag),
    .alu_ready  (alu_ready),
    .lsb_valid  (lsb_valid),
    .lsb_result (lsb_result),
    .lsb_rdTag  (lsb_rdTag),
    .lsb_ready  (lsb_ready),
    .cdb_valid  (cdb_valid),
    .cdb_result (cdb_result),
    .cdb_rdTag  (cdb_rdTag),
    .cdb_src    (cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t             q_alu[$];
  ent_t             q_lsb[$];
  logic             m_valid, m_src, m_prio;
  logic [31:0]      m_result;
  logic [TAG_W-1:0] m_tag;
  bit               a_acc, l_acc;
  int               n_chk, n_pass;

`ifdef CDB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  task automatic model_clear();
    q_alu.delete();
    q_lsb.delete();
    m_valid  = 1'b0;
    m_result = '0;
    m_tag    = '0;
    m_src    = 1'b0;
    m_prio   = 1'b0;
  endtask

  // One rising edge of the reference: arbitrate over what was queued before
  // the edge, then append this cycle's accepted completions.
  task automatic model_edge(input bit ra, input bit rl);
    ent_t e;
    int   g;
    if (rollback) begin
      q_alu.delete();
      q_lsb.delete();
      m_valid = 1'b0;
      m_prio  = 1'b0;
    end else if (rdy) begin
      g = -1;
      if (q_alu.size() > 0 && q_lsb.size() > 0) g = RR ? int'(m_prio) : 0;
      else if (q_alu.size() > 0)                g = 0;
      else if (q_lsb.size() > 0)                g = 1;
      if (g == 0) e = q_alu.pop_front();
      if (g == 1) e = q_lsb.pop_front();
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_result = e.res;
        m_tag    = e.tag;
        m_src    = (g == 1);
        m_prio   = (g == 0);
      end
      if (alu_valid && ra) q_alu.push_back('{alu_result, alu_rdTag});
      if (lsb_valid && rl) q_lsb.push_back('{lsb_result, lsb_rdTag});
    end
  endtask

  task automatic check_cdb();
    chk("cdb_valid",  64'(cdb_valid),  64'(m_valid));
    chk("cdb_result", 64'(cdb_result), 64'(m_result));
    chk("cdb_rdTag",  64'(cdb_rdTag),  64'(m_tag));
    chk("cdb_src",    64'(cdb_src),    64'(m_src));
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic tick();
    bit ra, rl;
    #1;
    ra = rdy && (q_alu.size() != QDEPTH);
    rl = rdy && (q_lsb.size() != QDEPTH);
    chk("alu_ready", 64'(alu_ready), 64'(ra));
    chk("lsb_ready", 64'(lsb_ready), 64'(rl));
    a_acc = alu_valid && ra;
    l_acc = lsb_valid && rl;
    @(posedge clk);
    model_edge(ra, rl);
    @(negedge clk);
    check_cdb();
  endtask

  // Sources hold their offer until it is taken, then maybe offer a new one.
  task automatic rand_step(input int p_src, input int p_rdy, input int p_rb);
    if (!alu_valid || a_acc) begin
      alu_valid  = ($urandom_range(99) < p_src);
      alu_result = $urandom;
      alu_rdTag  = TAG_W'($urandom);
    end
    if (!lsb_valid || l_acc) begin
      lsb_valid  = ($urandom_range(99) < p_src);
      lsb_result = $urandom;
      lsb_rdTag  = TAG_W'($urandom);
    end
    rdy      = ($urandom_range(99) < p_rdy);
    rollback = ($urandom_range(99) < p_rb);
    tick();
  endtask

  task automatic offer(input bit av, input logic [31:0] ar, input logic [TAG_W-1:0] at,
                       input bit lv, input logic [31:0] lr, input logic [TAG_W-1:0] lt);
    alu_valid  = av;
    alu_result = ar;
    alu_rdTag  = at;
    lsb_valid  = lv;
    lsb_result = lr;
    lsb_rdTag  = lt;
    tick();
  endtask

  task automatic idle(input int n);
    alu_valid = 1'b0;
    lsb_valid = 1'b0;
    rdy       = 1'b1;
    rollback  = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    a_acc = 1'b0;
    l_acc = 1'b0;
    rst = 1'b0;
    rdy = 1'b1;
    rollback = 1'b0;
    alu_valid = 1'b0;
    lsb_valid = 1'b0;
    alu_result = '0;
    lsb_result = '0;
    alu_rdTag = '0;
    lsb_rdTag = '0;
    model_clear();

    // Reset state, including ready following rdy while in reset.
    #3;
    check_cdb();
    chk("rst_alu_ready", 64'(alu_ready), 64'(rdy));
    rdy = 1'b0;
    #1;
    chk("rst_lsb_ready", 64'(lsb_ready), 64'(rdy));
    rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single ALU completion, two-edge latency.
    offer(1'b1, 32'h0000_1234, TAG_W'(3), 1'b0, '0, '0);
    chk("lat_edge1_valid", 64'(cdb_valid), 64'd0);
    offer(1'b0, '0, '0, 1'b0, '0, '0);
    chk("lat_valid", 64'(cdb_valid), 64'd1);
    chk("lat_result", 64'(cdb_result), 64'h1234);
    chk("lat_tag", 64'(cdb_rdTag), 64'd3);
    chk("lat_src", 64'(cdb_src), 64'd0);
    idle(2);

    // Simultaneous arrival: ALU first, LSB next cycle.
    offer(1'b1, 32'hA, TAG_W'(1), 1'b1, 32'hB, TAG_W'(2));
    offer(1'b0, '0, '0, 1'b0, '0, '0);
    chk("pair_first_src", 64'(cdb_src), 64'd0);
    idle(1);
    chk("pair_second_res", 64'(cdb_result), 64'hB);
    chk("pair_second_src", 64'(cdb_src), 64'd1);
    idle(2);

    // Both sources streaming; LSB backs up under fixed priority.
    for (int i = 0; i < 8; i++) rand_step(100, 100, 0);
    idle(6);

    // Rollback while frozen with buffers loaded.
    for (int i = 0; i < 4; i++) rand_step(100, 100, 0);
    alu_valid = 1'b1;
    lsb_valid = 1'b1;
    rdy = 1'b0;
    rollback = 1'b1;
    tick();
    chk("rb_valid", 64'(cdb_valid), 64'd0);
    rollback = 1'b0;
    rdy = 1'b1;
    alu_valid = 1'b0;
    lsb_valid = 1'b0;
    a_acc = 1'b0;
    l_acc = 1'b0;
    idle(4);

    // Asynchronous reset mid-stream, then a fresh push.
    for (int i = 0; i < 5; i++) rand_step(100, 100, 0);
    #2 rst = 1'b0;
    #1;
    model_clear();
    check_cdb();
    chk("arst_ready", 64'(alu_ready), 64'(rdy));
    alu_valid = 1'b0;
    lsb_valid = 1'b0;
    rdy = 1'b1;
    a_acc = 1'b0;
    l_acc = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    offer(1'b0, '0, '0, 1'b1, 32'hCAFE_0001, TAG_W'(9));
    offer(1'b0, '0, '0, 1'b0, '0, '0);
    chk("arst_fresh_res", 64'(cdb_result), 64'hCAFE_0001);
    idle(2);

    // Random traffic across a range of loads, stalls and flushes.
    for (int i = 0; i < 600; i++) rand_step(70, 80, 3);
    for (int i = 0; i < 600; i++) rand_step(95, 60, 1);
    for (int i = 0; i < 400; i++) rand_step(30, 95, 0);
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter QDEPTH, default 2, meaning per-source buffer depth in entries (power of two, >=2).
REQ-002 SHALL have parameter TAG_W, default 4, meaning ROB tag width (matches ROB index range).
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rdy, input, 1, global enable; low freezes all non-reset state.
REQ-006 SHALL have port rollback, input, 1, synchronous flush from the ROB.
REQ-007 SHALL have ports alu_valid in 1, alu_result in 32, alu_rdTag in TAG_W, alu_ready out 1: ALU completion handshake.
REQ-008 SHALL have ports lsb_valid in 1, lsb_result in 32, lsb_rdTag in TAG_W, lsb_ready out 1: LSB completion handshake.
REQ-009 SHALL have ports cdb_valid out 1, cdb_result out 32, cdb_rdTag out TAG_W, cdb_src out 1 (0=ALU, 1=LSB): the single shared common data bus.

Function
REQ-010 SHALL give each source its own FIFO of QDEPTH entries holding {result, rdTag}; read/write pointers wrap modulo QDEPTH; occupancy count width clog2(QDEPTH+1).
REQ-011 SHALL drive x_ready = rdy & (count_x != QDEPTH), combinationally from the pre-edge count; no dependence on same-cycle pop.
REQ-012 SHALL push an entry when x_valid & x_ready at a rising edge; x_valid without x_ready drops nothing (source holds).
REQ-013 SHALL grant at most one non-empty FIFO per rdy-high cycle, pop its head, and register it onto cdb_* at the same edge.
REQ-014 SHALL make latency exactly 2 edges: push at edge t into an empty FIFO, cdb_valid high after edge t+1 when granted.
REQ-015 SHALL deassert cdb_valid after any rdy-high edge with no grant; cdb_result/cdb_rdTag/cdb_src then hold last values.
REQ-016 SHALL allow simultaneous push and pop on one FIFO in a cycle, count unchanged.
REQ-017 SHALL, with arbitration per REQ-026/027, never grant an empty FIFO and never lose or duplicate an entry.
REQ-018 SHALL, on rollback high at an edge (regardless of rdy), empty both FIFOs, clear cdb_valid, reset the priority pointer to ALU, and discard same-cycle pushes.
REQ-019 SHALL, when rdy is low and rollback low, perform no push, no pop, and hold every register including cdb_valid.

Reset
REQ-020 SHALL, while rst is low, asynchronously force cdb_valid=0, cdb_result=0, cdb_rdTag=0, cdb_src=0, both FIFO counts and pointers 0, priority pointer = ALU.
REQ-021 SHALL, as a consequence, present alu_ready=lsb_ready=rdy during and after reset.
REQ-022 SHALL resume normal operation on the first rising edge after rst deasserts.

Configuration
REQ-023 SHALL honour macro CDB_ARB_RR_EN selecting the arbitration policy.
REQ-024 SHALL, with CDB_ARB_RR_EN defined, use round-robin: after granting source s, the other source has priority next.
REQ-025 SHALL, without CDB_ARB_RR_EN, use fixed priority ALU over LSB; LSB starvation under continuous ALU traffic is accepted.
REQ-026 SHALL, under round-robin with both non-empty, alternate grants every rdy-high cycle.
REQ-027 SHALL, under round-robin with one non-empty, grant it regardless of pointer and update the pointer.

Structure
REQ-028 SHALL place TAG_W default, source encodings SRC_ALU=0/SRC_LSB=1 and the {result, rdTag} payload typedef in shared package cdb_pkg.
REQ-029 SHALL implement each buffer as one sub-module cdb_fifo, instantiated twice.

Verification
REQ-030 SHALL cover: ALU push {0x0000_1234, tag 3} into idle arbiter -> cdb_valid one cycle two edges later, result 0x1234, tag 3, src 0.
REQ-031 SHALL cover: ALU {0xA,1} and LSB {0xB,2} pushed same edge, RR built -> cdb order ALU then LSB on consecutive cycles; without macro same order.
REQ-032 SHALL cover: both sources push every cycle for 8 cycles -> RR build alternates src 0,1,0,1; fixed build shows src 0 only while ALU busy.
REQ-033 SHALL cover: fill LSB FIFO to QDEPTH=2 with ALU busy, fixed build -> lsb_ready=0, third LSB value held and later delivered intact.
REQ-034 SHALL cover: rollback asserted with both FIFOs holding 2 entries and rdy=0 -> next cycle cdb_valid=0, both ready=rdy, no stale tag ever broadcast.
REQ-035 SHALL cover: rst pulled low mid-stream (asynchronous, between edges) -> cdb_valid drops immediately, all entries lost, fresh push after release delivered with 2-edge latency.
